// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller:
// FSM states, datapath select codes, instruction field codes and the condition table.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } statetype;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // flags are packed {N,Z,C,V}; the reserved 1111 code never executes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Condition logic: registered ALU flags, condition evaluation, the per-instruction
// CondExR flop and gating of the conditional write enables.
module mc_condlogic
    import arm_ctrl_pkg::*;
#(
    parameter bit COND_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_cond_latch,
    input  logic       i_flag_w_nz,
    input  logic       i_flag_w_cv,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    input  logic       i_pc_s,
    output logic       o_reg_write,
    output logic       o_mem_write,
    output logic       o_pc_write
);

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;

    assign w_cond_ex = COND_EN ? cond_check(i_cond, r_flags) : 1'b1;

    // Flags and CondExR; an instruction only touches the flags if it passed its own condition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            if (i_cond_latch) begin
                r_cond_ex <= w_cond_ex;
            end
            if (i_flag_w_nz & r_cond_ex) begin
                r_flags[3:2] <= i_alu_flags[3:2];
            end
            if (i_flag_w_cv & r_cond_ex) begin
                r_flags[1:0] <= i_alu_flags[1:0];
            end
        end
    end

    assign o_reg_write = i_reg_w & r_cond_ex;
    assign o_mem_write = i_mem_w & r_cond_ex;
    assign o_pc_write  = i_pc_s & r_cond_ex;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM controller: Moore FSM, main decoder and ALU decoder.
// Drives every enable and mux select of the multicycle datapath.
module mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b0,
    parameter bit BYTE_EN     = 1'b1,
    parameter bit COND_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         MemReady,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         IRWrite,
    output logic         MemWrite,
    output logic         MemByte,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [2:0]   ALUControl
);

    statetype   r_state;
    statetype   w_next;
    statetype   w_state;
    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_i;
    logic       w_u;
    logic       w_b;
    logic       w_l;
    logic       w_rd15;
    logic       w_mem_done;
    logic [2:0] w_alu_cmd;
    logic       w_no_write;
    logic       w_arith;
    logic       w_pc_fetch;
    logic       w_ir_write;
    logic       w_mem_access;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_pc_s;
    logic       w_cond_latch;
    logic       w_exec;
    logic       w_reg_write_g;
    logic       w_mem_write_g;
    logic       w_pc_write_g;
    logic       w_unused;

    assign w_op       = Instr[27:26];
    assign w_i        = Instr[25];
    assign w_cmd      = Instr[24:21];
    assign w_u        = Instr[23];
    assign w_b        = Instr[22];
    assign w_l        = Instr[20];
    assign w_rd15     = (Instr[15:12] == 4'hF);
    assign w_unused   = &{1'b0, Instr[19:16]};
    assign w_mem_done = ~MEM_WAIT_EN | MemReady;

    // Holding reset forces the FETCH decode so selects are stable and enables are low
    assign w_state = reset ? S_FETCH : r_state;

    // ALU decoder; unknown commands run as ADD but never write back
    always_comb begin
        w_alu_cmd  = ALU_ADD;
        w_no_write = 1'b0;
        w_arith    = 1'b0;
        case (w_cmd)
            CMD_ADD: begin w_alu_cmd = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_alu_cmd = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_alu_cmd = ALU_AND;
            CMD_ORR: w_alu_cmd = ALU_ORR;
            CMD_EOR: w_alu_cmd = ALU_EOR;
            CMD_CMP: begin w_alu_cmd = ALU_SUB; w_arith = 1'b1; w_no_write = 1'b1; end
            default: begin w_alu_cmd = ALU_ADD; w_no_write = 1'b1; end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = w_mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    OP_MEM:  w_next = S_MEMADR;
                    OP_DP:   w_next = w_i ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = w_l ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_mem_done ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_mem_done ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Moore output decode; conditional enables go through the condition logic
    always_comb begin
        w_pc_fetch   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_access = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_pc_s       = 1'b0;
        w_cond_latch = 1'b0;
        w_exec       = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RD2;
        ALUControl   = ALU_ADD;
        case (w_state)
            S_FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                w_ir_write = w_mem_done;
                w_pc_fetch = w_mem_done;
            end
            S_DECODE: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_cond_latch = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = w_u ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_mem_access = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                w_reg_w   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                w_mem_access = 1'b1;
                w_mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                ALUControl = w_alu_cmd;
                w_exec     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = w_alu_cmd;
                w_exec     = 1'b1;
            end
            S_ALUWB: begin
                w_reg_w = ~w_no_write;
                w_pc_s  = w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                w_pc_s    = 1'b1;
            end
            default: begin
                w_pc_fetch = 1'b0;
            end
        endcase
    end

    mc_condlogic #(
        .COND_EN (COND_EN)
    ) u_cond (
        .clk          (clk),
        .reset        (reset),
        .i_cond       (Instr[31:28]),
        .i_alu_flags  (ALUFlags),
        .i_cond_latch (w_cond_latch),
        .i_flag_w_nz  (w_exec & Instr[20]),
        .i_flag_w_cv  (w_exec & Instr[20] & w_arith),
        .i_reg_w      (w_reg_w),
        .i_mem_w      (w_mem_w),
        .i_pc_s       (w_pc_s),
        .o_reg_write  (w_reg_write_g),
        .o_mem_write  (w_mem_write_g),
        .o_pc_write   (w_pc_write_g)
    );

    assign PCWrite  = ~reset & (w_pc_fetch | w_pc_write_g);
    assign IRWrite  = ~reset & w_ir_write;
    assign MemWrite = ~reset & w_mem_write_g;
    assign RegWrite = ~reset & w_reg_write_g;
    assign MemByte  = BYTE_EN & w_mem_access & w_b;
    assign ImmSrc   = w_op;
    assign RegSrc   = {(w_op == OP_MEM) & ~w_l, (w_op == OP_BR)};

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one default instance and one with the memory
// wait handshake enabled and byte access disabled, both driven from shared inputs.
module tb_mc_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] instr;
    logic [3:0]   alu_flags;
    logic         mem_ready;

    logic       a_pcw, a_adr, a_irw, a_mw, a_mb, a_rw, a_asa;
    logic [1:0] a_rs, a_asb, a_imm, a_rsrc;
    logic [2:0] a_alu;
    logic       b_pcw, b_adr, b_irw, b_mw, b_mb, b_rw, b_asa;
    logic [1:0] b_rs, b_asb, b_imm, b_rsrc;
    logic [2:0] b_alu;
    logic [17:0] vec_a;
    logic [17:0] vec_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:12] ins;
        logic [2:0]   alu;
        logic [1:0]   wb;
    } dp_vec_t;
    dp_vec_t dp_tab [8];

    always #5 clk = ~clk;

    mc_controller u_dut_a (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags), .MemReady(mem_ready),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .IRWrite(a_irw), .MemWrite(a_mw), .MemByte(a_mb),
        .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ImmSrc(a_imm),
        .RegSrc(a_rsrc), .ALUControl(a_alu)
    );

    mc_controller #(.MEM_WAIT_EN(1'b1), .BYTE_EN(1'b0), .COND_EN(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags), .MemReady(mem_ready),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .IRWrite(b_irw), .MemWrite(b_mw), .MemByte(b_mb),
        .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ImmSrc(b_imm),
        .RegSrc(b_rsrc), .ALUControl(b_alu)
    );

    assign vec_a = {a_pcw, a_adr, a_irw, a_mw, a_mb, a_rw, a_rs, a_asa, a_asb, a_imm, a_rsrc, a_alu};
    assign vec_b = {b_pcw, b_adr, b_irw, b_mw, b_mb, b_rw, b_rs, b_asa, b_asb, b_imm, b_rsrc, b_alu};

    function automatic logic [17:0] sig(input logic pcw, adr, irw, mw, mb, rw,
                                        input logic [1:0] rs, input logic asa,
                                        input logic [1:0] asb, imm, rsrc,
                                        input logic [2:0] alu);
        return {pcw, adr, irw, mw, mb, rw, rs, asa, asb, imm, rsrc, alu};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        dp_tab[0] = '{20'hE0821, 3'b000, 2'b01};
        dp_tab[1] = '{20'hE0421, 3'b001, 2'b01};
        dp_tab[2] = '{20'hE0021, 3'b010, 2'b01};
        dp_tab[3] = '{20'hE1821, 3'b011, 2'b01};
        dp_tab[4] = '{20'hE0221, 3'b100, 2'b01};
        dp_tab[5] = '{20'hE0E21, 3'b000, 2'b00};
        dp_tab[6] = '{20'hE082F, 3'b000, 2'b11};
        dp_tab[7] = '{20'h12800, 3'b000, 2'b01};

        // ADD R1,R2,R3 through FETCH/DECODE/EXECUTER/ALUWB
        reset = 1'b1; instr = 20'hE0821; alu_flags = 4'b0000; mem_ready = 1'b1;
        tick(); tick();
        check_val("rst_out_a", vec_a, sig(0,0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));
        check_val("rst_out_b", vec_b, sig(0,0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));
        reset = 1'b0; #1;
        check_val("add_fetch", vec_a, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));
        tick();
        check_val("add_decode", vec_a, sig(0,0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));
        tick();
        check_val("add_exec", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000));
        tick();
        check_val("add_aluwb", vec_a, sig(0,0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,3'b000));
        tick();
        check_val("add_refetch", vec_a, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));

        // LDR with MemReady low for three MEMREAD cycles on the waiting instance
        instr = 20'hE5910;
        do_reset();
        check_val("ldr_fetch_b", vec_b, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b01,2'b00,3'b000));
        tick();
        check_val("ldr_decode_b", vec_b, sig(0,0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,3'b000));
        tick();
        check_val("ldr_memadr_b", vec_b, sig(0,0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,3'b000));
        tick();
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("ldr_wait%0d_b", i), vec_b,
                      sig(0,1,0,0,0,0,2'b00,0,2'b00,2'b01,2'b00,3'b000));
            tick();
        end
        mem_ready = 1'b1; #1;
        check_val("ldr_memread_done_b", vec_b, sig(0,1,0,0,0,0,2'b00,0,2'b00,2'b01,2'b00,3'b000));
        tick();
        check_val("ldr_memwb_b", vec_b, sig(0,0,0,0,0,1,2'b01,0,2'b00,2'b01,2'b00,3'b000));
        tick();
        check_val("ldr_refetch_b", vec_b, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b01,2'b00,3'b000));

        // CMP sets Z, BEQ taken; then CMP clears Z, BEQ not taken
        instr = 20'hE1510; alu_flags = 4'b0100;
        do_reset();
        tick(); tick();
        check_val("cmp_exec", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b001));
        tick();
        check_val("cmp_aluwb", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000));
        check_val("cmp_flags_z", u_dut_a.u_cond.r_flags, 4'b0100);
        tick();
        instr = 20'h0A000; #1;
        check_val("beq_fetch", vec_a, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b10,2'b01,3'b000));
        tick(); tick();
        check_val("beq_taken", vec_a, sig(1,0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000));
        tick();
        instr = 20'hE1510; alu_flags = 4'b0000;
        tick(); tick(); tick(); tick();
        instr = 20'h0A000;
        tick(); tick();
        check_val("beq_not_taken", vec_a, sig(0,0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000));
        tick();

        // STRB on both instances: byte only where byte access is enabled
        instr = 20'hE5C12;
        tick(); tick();
        check_val("strb_memadr", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b10,3'b000));
        tick();
        check_val("strb_memwrite_a", vec_a, sig(0,1,0,1,1,0,2'b00,0,2'b00,2'b01,2'b10,3'b000));
        check_val("strb_memwrite_b", vec_b, sig(0,1,0,1,0,0,2'b00,0,2'b00,2'b01,2'b10,3'b000));
        tick();

        // Reset during a MEMWRITE wait on the waiting instance, with non-zero flags
        instr = 20'hE1510; alu_flags = 4'b1001;
        tick(); tick(); tick();
        check_val("cmp2_flags_b", u_dut_b.u_cond.r_flags, 4'b1001);
        tick();
        instr = 20'hE5C12;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        check_val("strw_wait0_b", vec_b, sig(0,1,0,1,0,0,2'b00,0,2'b00,2'b01,2'b10,3'b000));
        tick();
        check_val("strw_wait1_b", vec_b, sig(0,1,0,1,0,0,2'b00,0,2'b00,2'b01,2'b10,3'b000));
        reset = 1'b1; #1;
        check_val("strw_rst_drop_b", vec_b, sig(0,0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b10,3'b000));
        tick();
        reset = 1'b0; mem_ready = 1'b1; #1;
        check_val("strw_rst_fetch_b", vec_b, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b01,2'b10,3'b000));
        check_val("strw_rst_flags_b", u_dut_b.u_cond.r_flags, 4'b0000);

        // ADDNE with Z=1 is squashed but still returns to FETCH
        instr = 20'hE1510; alu_flags = 4'b0100;
        tick(); tick(); tick(); tick();
        instr = 20'h12800;
        tick(); tick();
        check_val("addne_execi", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,3'b000));
        tick();
        check_val("addne_aluwb", vec_a, sig(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000));
        tick();
        check_val("addne_refetch", vec_a, sig(1,0,1,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000));

        // Data-processing command table from reset (flags clear)
        alu_flags = 4'b0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            instr = dp_tab[i].ins;
            tick(); tick();
            check_val($sformatf("dp%0d_alu", i), a_alu, dp_tab[i].alu);
            tick();
            check_val($sformatf("dp%0d_wb", i), {a_pcw, a_rw}, dp_tab[i].wb);
            tick();
        end

        // LDR with U=0 subtracts the offset
        instr = 20'hE5110;
        tick(); tick();
        check_val("ldr_sub_memadr", a_alu, 3'b001);
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
